// File: rtl/sync_fifo_flex_pkg.sv
// sync_fifo_flex_pkg: read-mode encodings and address-width helper shared by the FIFO files
package sync_fifo_flex_pkg;
  localparam int RD_STD = 0;
  localparam int RD_FWFT = 1;
  function automatic int clog2(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port on a single clock
module sdp_ram #(
  parameter int DATA = 8,
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [ADDR-1:0] waddr,
  input  logic [DATA-1:0] din,
  input  logic            re,
  input  logic [ADDR-1:0] raddr,
  output logic [DATA-1:0] dout
);
  logic [DATA-1:0] mem_q [0:(1<<ADDR)-1];
  // array write and synchronous read; contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= din;
    if (re) dout <= mem_q[raddr];
  end
endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with standard or first-word-fall-through read, fill count and flags
module sync_fifo_flex
  import sync_fifo_flex_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 1024,
  parameter int AWIDTH    = clog2(DEPTH),
  parameter int FWFT      = RD_STD,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [AWIDTH:0] FULL_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C = (AWIDTH+1)'(AF_THRESH);
  localparam logic [AWIDTH:0] AE_C = (AWIDTH+1)'(AE_THRESH);
  logic [AWIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic empty_q, full_q, ae_q, af_q, ovf_q, udf_q;
  logic wr_acc, rd_acc, rd_adv, ram_re, ram_nonempty, head_v_d;
  logic [WIDTH-1:0] ram_q, dout_q;
  assign wr_acc = wr & ~full_q;
  assign rd_acc = rd & ~empty_q;
  assign ram_nonempty = wr_ptr_q != rd_ptr_q;
  // next pointers and fill count; a flush overrides any transfer
  always_comb begin
    wr_ptr_d = clr ? '0 : wr_ptr_q + (AWIDTH+1)'(wr_acc);
    rd_ptr_d = clr ? '0 : rd_ptr_q + (AWIDTH+1)'(rd_adv);
    count_d = clr ? '0 : count_q + (AWIDTH+1)'(wr_acc) - (AWIDTH+1)'(rd_acc);
  end
  // pointer/count state and flags decoded from the next count so they line up with count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      ae_q <= 1'b1;
      af_q <= AF_C == '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      empty_q <= (FWFT == RD_FWFT) ? ~head_v_d : count_d == '0;
      full_q <= count_d == FULL_C;
      ae_q <= count_d <= AE_C;
      af_q <= count_d >= AF_C;
      ovf_q <= ~clr & wr & full_q;
      udf_q <= ~clr & rd & empty_q;
    end
  sdp_ram #(.DATA(WIDTH), .ADDR(AWIDTH)) u_ram (
    .clk,
    .we(wr_acc & ~clr),
    .waddr(wr_ptr_q[AWIDTH-1:0]),
    .din,
    .re(ram_re),
    .raddr(rd_ptr_q[AWIDTH-1:0]),
    .dout(ram_q)
  );
  if (FWFT == RD_FWFT) begin : g_fwft
    logic mid_v_q, load, fetch;
    assign load = mid_v_q & (empty_q | rd_acc);
    assign fetch = ram_nonempty & (~mid_v_q | load);
    assign head_v_d = ~clr & (load | (~empty_q & ~rd_acc));
    assign rd_adv = fetch;
    assign ram_re = fetch;
    // two-stage prefetch: RAM output acts as skid word behind the head word on dout
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        mid_v_q <= 1'b0;
        dout_q <= '0;
      end else begin
        mid_v_q <= ~clr & (fetch | (mid_v_q & ~load));
        dout_q <= clr ? '0 : load ? ram_q : dout_q;
      end
  end else begin : g_std
    logic rv_q;
    assign head_v_d = 1'b0;
    assign rd_adv = rd_acc;
    assign ram_re = rd_acc & ram_nonempty;
    // output register loads the RAM word one cycle after the accepted read
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rv_q <= 1'b0;
        dout_q <= '0;
      end else begin
        rv_q <= ~clr & rd_acc;
        dout_q <= clr ? '0 : rv_q ? ram_q : dout_q;
      end
  end
  assign dout = dout_q;
  assign empty = empty_q;
  assign full = full_q;
  assign almost_empty = ae_q;
  assign almost_full = af_q;
  assign count = count_q;
  assign overflow = ovf_q;
  assign underflow = udf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: table-driven check of standard and FWFT FIFO instances sharing one stimulus
module tb_sync_fifo_flex;
  localparam int W = 8, D = 8, AF = 6, AE = 2;
  typedef struct {
    logic wr, rd, clr;
    logic [7:0] din;
    logic [3:0] cnt;
    logic es, ef, fu, ae, af, ov, ud;
    logic [7:0] ds, df;
  } vec_t;
  vec_t vq[$];
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout_s, dout_f;
  logic [3:0] cnt_s, cnt_f;
  logic empty_s, full_s, ae_s, af_s, ov_s, ud_s;
  logic empty_f, full_f, ae_f, af_f, ov_f, ud_f;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .din(din), .rd(rd), .dout(dout_s),
    .empty(empty_s), .full(full_s), .almost_empty(ae_s), .almost_full(af_s),
    .count(cnt_s), .overflow(ov_s), .underflow(ud_s));
  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fw (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .din(din), .rd(rd), .dout(dout_f),
    .empty(empty_f), .full(full_f), .almost_empty(ae_f), .almost_full(af_f),
    .count(cnt_f), .overflow(ov_f), .underflow(ud_f));

  function automatic logic [17:0] pk(input logic [3:0] c, input logic e, f, a, b, o, u,
                                     input logic [7:0] d);
    return {c, e, f, a, b, o, u, d};
  endfunction

  task automatic chk(input string n, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic add(input logic wr_, rd_, clr_, input logic [7:0] din_, input logic [3:0] cnt_,
                     input logic es_, ef_, fu_, ae_, af_, ov_, ud_, input logic [7:0] ds_, df_);
    vq.push_back('{wr_, rd_, clr_, din_, cnt_, es_, ef_, fu_, ae_, af_, ov_, ud_, ds_, df_});
  endtask

  function automatic logic [17:0] act_s();
    return pk(cnt_s, empty_s, full_s, ae_s, af_s, ov_s, ud_s, dout_s);
  endfunction

  function automatic logic [17:0] act_f();
    return pk(cnt_f, empty_f, full_f, ae_f, af_f, ov_f, ud_f, dout_f);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    if (!(AE >= 0 && AE < AF && AF <= D)) $fatal(1, "bad threshold parameters");
    for (int k = 1; k <= 8; k++)
      add('1, '0, '0, 8'(15 + k), 4'(k), '0, k <= 2, k == 8, k <= 2, k >= 6, '0, '0,
          8'h00, (k >= 3) ? 8'h10 : 8'h00);
    add('1, '0, '0, 8'h18, 4'd8, '0, '0, '1, '0, '1, '1, '0, 8'h00, 8'h10);
    add('0, '0, '0, 8'h00, 4'd8, '0, '0, '1, '0, '1, '0, '0, 8'h00, 8'h10);
    for (int k = 1; k <= 8; k++)
      add('0, '1, '0, 8'h00, 4'(8 - k), k == 8, k == 8, '0, (8 - k) <= 2, (8 - k) >= 6, '0, '0,
          (k >= 2) ? 8'(14 + k) : 8'h00, (k <= 7) ? 8'(16 + k) : 8'h17);
    add('0, '1, '0, 8'h00, 4'd0, '1, '1, '0, '1, '0, '0, '1, 8'h17, 8'h17);
    add('0, '0, '0, 8'h00, 4'd0, '1, '1, '0, '1, '0, '0, '0, 8'h17, 8'h17);
    for (int k = 1; k <= 4; k++)
      add('1, '0, '0, 8'(31 + k), 4'(k), '0, k <= 2, '0, k <= 2, '0, '0, '0,
          8'h17, (k >= 3) ? 8'h20 : 8'h17);
    for (int k = 1; k <= 20; k++)
      add('1, '1, '0, 8'(35 + k), 4'd4, '0, '0, '0, '0, '0, '0, '0,
          (k >= 2) ? 8'(30 + k) : 8'h17, 8'(32 + k));
    add('1, '0, '0, 8'h40, 4'd5, '0, '0, '0, '0, '0, '0, '0, 8'h33, 8'h34);
    add('1, '0, '1, 8'h99, 4'd0, '1, '1, '0, '1, '0, '0, '0, 8'h00, 8'h00);
    add('0, '0, '0, 8'h00, 4'd0, '1, '1, '0, '1, '0, '0, '0, 8'h00, 8'h00);
    add('1, '0, '0, 8'hA5, 4'd1, '0, '1, '0, '1, '0, '0, '0, 8'h00, 8'h00);
    add('0, '0, '0, 8'h00, 4'd1, '0, '1, '0, '1, '0, '0, '0, 8'h00, 8'h00);
    add('0, '0, '0, 8'h00, 4'd1, '0, '0, '0, '1, '0, '0, '0, 8'h00, 8'hA5);
    add('0, '1, '0, 8'h00, 4'd0, '1, '1, '0, '1, '0, '0, '0, 8'h00, 8'hA5);
    add('0, '0, '0, 8'h00, 4'd0, '1, '1, '0, '1, '0, '0, '0, 8'hA5, 8'hA5);
    add('1, '1, '1, 8'h77, 4'd0, '1, '1, '0, '1, '0, '0, '0, 8'h00, 8'h00);
    add('0, '0, '0, 8'h00, 4'd0, '1, '1, '0, '1, '0, '0, '0, 8'h00, 8'h00);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset std", act_s(), pk(4'd0, 1, 0, 1, 0, 0, 0, 8'h00));
    chk("reset fwft", act_f(), pk(4'd0, 1, 0, 1, 0, 0, 0, 8'h00));

    foreach (vq[i]) begin
      wr = vq[i].wr;
      rd = vq[i].rd;
      clr = vq[i].clr;
      din = vq[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d std", i), act_s(),
          pk(vq[i].cnt, vq[i].es, vq[i].fu, vq[i].ae, vq[i].af, vq[i].ov, vq[i].ud, vq[i].ds));
      chk($sformatf("vec%0d fwft", i), act_f(),
          pk(vq[i].cnt, vq[i].ef, vq[i].fu, vq[i].ae, vq[i].af, vq[i].ov, vq[i].ud, vq[i].df));
    end

    wr = 1'b1; rd = 1'b0; clr = 1'b0; din = 8'h61;
    @(posedge clk);
    #1;
    din = 8'h62;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst std", act_s(), pk(4'd0, 1, 0, 1, 0, 0, 0, 8'h00));
    chk("async rst fwft", act_f(), pk(4'd0, 1, 0, 1, 0, 0, 0, 8'h00));
    wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr = 1'b1; din = 8'h3C;
    @(posedge clk);
    #1;
    wr = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("post-rst write std", act_s(), pk(4'd1, 0, 0, 1, 0, 0, 0, 8'h00));
    chk("post-rst write fwft", act_f(), pk(4'd1, 0, 0, 1, 0, 0, 0, 8'h3C));
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst read std", act_s(), pk(4'd0, 1, 0, 1, 0, 0, 0, 8'h3C));
    chk("post-rst read fwft", act_f(), pk(4'd0, 1, 0, 1, 0, 0, 0, 8'h3C));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
